// File: rtl/alu_seq_w_if.sv
// Handshake and operand/result bundle between the decode stage, alu_seq_w and writeback.
interface alu_seq_w_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [WIDTH-1:0]  src1_i;
  logic [WIDTH-1:0]  src2_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WIDTH-1:0]  result_o;
  logic              zero_o;
  logic              overflow_o;
  logic              cout_o;

  modport master (
    output in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, overflow_o, cout_o
  );

  modport slave (
    input  in_valid_i, src1_i, src2_i, ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, overflow_o, cout_o
  );
endinterface

// File: rtl/alu_seq_w.sv
// WIDTH-bit ALU with valid/ready handshake: single-cycle logic/add/sub/slt,
// iterative shift-add unsigned multiply (one multiplier bit per cycle).
module alu_seq_w #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input logic         clk_i,
  input logic         rst_n,
  alu_seq_w_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(4'b1000);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic               in_ready, accept, is_mul, is_sub;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   result;
  logic               zero, ovf, cout;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   op_res;
  logic               op_ovf, op_cout, op_known;

  // Single-cycle datapath works straight off the inputs so the result lands at the accept edge.
  always_comb begin
    is_sub   = (bus.ctrl_i == OP_SUB) || (bus.ctrl_i == OP_SLT);
    is_mul   = (bus.ctrl_i == OP_MUL);
    b_eff    = is_sub ? ~bus.src2_i : bus.src2_i;
    sum      = {1'b0, bus.src1_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf  = (bus.src1_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
    op_res   = '0;
    op_ovf   = 1'b0;
    op_cout  = 1'b0;
    op_known = 1'b1;
    case (bus.ctrl_i)
      OP_AND: op_res = bus.src1_i & bus.src2_i;
      OP_OR:  op_res = bus.src1_i | bus.src2_i;
      OP_ADD, OP_SUB: begin
        op_res  = sum[WIDTH-1:0];
        op_ovf  = add_ovf;
        op_cout = sum[WIDTH];
      end
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_NOR: op_res = ~(bus.src1_i | bus.src2_i);
      default: op_known = 1'b0;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE) || ((state == DONE) && bus.out_ready_i);
    accept     = bus.in_valid_i && in_ready;
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? BUSY : DONE;
      BUSY: if (cnt == CNT_W'(WIDTH-1)) state_next = DONE;
      DONE: if (bus.out_ready_i) state_next = accept ? (is_mul ? BUSY : DONE) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      cout   <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, bus.src1_i};
        mplier <= bus.src2_i;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        // Unknown codes clear every flag, including zero, even though result is 0.
        result <= op_res;
        zero   <= op_known && (op_res == '0);
        ovf    <= op_ovf;
        cout   <= op_cout;
      end
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(WIDTH-1)) begin
        result <= acc_step[WIDTH-1:0];
        zero   <= (acc_step[WIDTH-1:0] == '0);
        ovf    <= |acc_step[2*WIDTH-1:WIDTH];
        cout   <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state == DONE);
  assign bus.result_o    = result;
  assign bus.zero_o      = zero;
  assign bus.overflow_o  = ovf;
  assign bus.cout_o      = cout;
endmodule

// File: tb/tb_alu_seq_w.sv
// Directed self-checking bench for alu_seq_w at WIDTH=32.
module tb_alu_seq_w;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  alu_seq_w_if #(.WIDTH(32), .CTRL_W(4)) bus ();
  alu_seq_w #(.WIDTH(32), .CTRL_W(4)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [34:0] obs();
    return {bus.result_o, bus.zero_o, bus.overflow_o, bus.cout_o};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [34:0] res);
    int guard;
    @(negedge clk);
    bus.ctrl_i = op; bus.src1_i = a; bus.src2_i = b; bus.in_valid_i = 1'b1;
    guard = 0;
    while (!bus.in_ready_o && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.src1_i = ~a; bus.src2_i = ~b; bus.ctrl_i = 4'b1111;
    lat = 1;
    while (!bus.out_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    res = obs();
  endtask

  task automatic consume();
    @(negedge clk); bus.out_ready_i = 1'b1;
    @(posedge clk); #1; bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.src1_i = '0; bus.src2_i = '0; bus.ctrl_i = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, obs()} !== {1'b1, 1'b0, 35'h0})
      $display("FAIL reset_state: got %h want %h", {bus.in_ready_o, bus.out_valid_o, obs()}, {1'b1, 1'b0, 35'h0});
    else passes++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic [34:0] r;
    run_op(4'b0010, 32'h7FFFFFFF, 32'h1, lat, r);
    checks++; if (lat !== 1) $display("FAIL add_lat: got %0d want 1", lat); else passes++;
    checks++; if (r !== {32'h80000000, 1'b0, 1'b1, 1'b0}) $display("FAIL add_res: got %h want %h", r, {32'h80000000, 3'b010}); else passes++;
    consume();
  endtask

  task automatic test_sub_slt();
    int lat; logic [34:0] r;
    run_op(4'b0110, 32'd5, 32'd5, lat, r);
    checks++; if (r !== {32'h0, 3'b101}) $display("FAIL sub_res: got %h want %h", r, {32'h0, 3'b101}); else passes++;
    consume();
    run_op(4'b0111, 32'hFFFFFFFF, 32'h1, lat, r);
    checks++; if (r !== {32'h1, 3'b000}) $display("FAIL slt_neg: got %h want %h", r, {32'h1, 3'b000}); else passes++;
    consume();
    run_op(4'b0111, 32'h80000000, 32'h1, lat, r);
    checks++; if (r !== {32'h1, 3'b000}) $display("FAIL slt_ovf: got %h want %h", r, {32'h1, 3'b000}); else passes++;
    consume();
  endtask

  task automatic test_logic();
    int lat; logic [34:0] r;
    run_op(4'b1100, 32'h0000FFFF, 32'h00FF0000, lat, r);
    checks++; if (r !== {32'hFF000000, 3'b000}) $display("FAIL nor_res: got %h want %h", r, {32'hFF000000, 3'b000}); else passes++;
    consume();
    run_op(4'b0000, 32'h12345678, 32'h0F0F0000, lat, r);
    checks++; if (r !== {32'h02040000, 3'b000}) $display("FAIL and_res: got %h want %h", r, {32'h02040000, 3'b000}); else passes++;
    consume();
  endtask

  task automatic test_mul();
    int lat; logic [34:0] r;
    run_op(4'b1000, 32'h0000FFFF, 32'h00010001, lat, r);
    checks++; if (lat !== 33) $display("FAIL mul_lat: got %0d want 33", lat); else passes++;
    checks++; if (r !== {32'hFFFFFFFF, 3'b000}) $display("FAIL mul_res: got %h want %h", r, {32'hFFFFFFFF, 3'b000}); else passes++;
    consume();
    run_op(4'b1000, 32'h00010000, 32'h00010000, lat, r);
    checks++; if (r !== {32'h0, 3'b110}) $display("FAIL mul_ovf: got %h want %h", r, {32'h0, 3'b110}); else passes++;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4] = '{32'd1, 32'd10, 32'hFFFFFFFF, 32'h40000000};
    logic [31:0] b [4] = '{32'd2, 32'd20, 32'h1, 32'h40000000};
    logic [34:0] e [4] = '{{32'd3, 3'b000}, {32'd30, 3'b000}, {32'h0, 3'b101}, {32'h80000000, 3'b010}};
    @(negedge clk); bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1; bus.ctrl_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      bus.src1_i = a[i]; bus.src2_i = b[i];
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid_o, obs()} !== {1'b1, e[i]})
        $display("FAIL b2b_%0d: got %h want %h", i, {bus.out_valid_o, obs()}, {1'b1, e[i]});
      else passes++;
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL b2b_drain: got %b want 0", bus.out_valid_o); else passes++;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_hold();
    int lat; logic [34:0] r;
    run_op(4'b0001, 32'h0F, 32'hF0, lat, r);
    checks++; if (r !== {32'hFF, 3'b000}) $display("FAIL hold_or: got %h want %h", r, {32'hFF, 3'b000}); else passes++;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.ctrl_i = 4'b0000; bus.src1_i = 32'hF0F0; bus.src2_i = 32'hFF00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.in_ready_o, bus.out_valid_o, obs()} !== {2'b01, 32'hFF, 3'b000})
        $display("FAIL hold_%0d: got %h want %h", i, {bus.in_ready_o, bus.out_valid_o, obs()}, {2'b01, 32'hFF, 3'b000});
      else passes++;
    end
    @(negedge clk); bus.out_ready_i = 1'b1; #1;
    checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL hold_release_ready: got %b want 1", bus.in_ready_o); else passes++;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    checks++;
    if ({bus.out_valid_o, obs()} !== {1'b1, 32'hF000, 3'b000})
      $display("FAIL hold_next: got %h want %h", {bus.out_valid_o, obs()}, {1'b1, 32'hF000, 3'b000});
    else passes++;
    @(posedge clk); #1; bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset_busy();
    int lat; logic [34:0] r;
    @(negedge clk);
    bus.ctrl_i = 4'b1000; bus.src1_i = 32'd3; bus.src2_i = 32'd5; bus.in_valid_i = 1'b1;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, obs()} !== {1'b1, 1'b0, 35'h0})
      $display("FAIL reset_busy: got %h want %h", {bus.in_ready_o, bus.out_valid_o, obs()}, {1'b1, 1'b0, 35'h0});
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    run_op(4'b0000, 32'hF0F0, 32'hFF00, lat, r);
    checks++; if (r !== {32'hF000, 3'b000}) $display("FAIL and_after_reset: got %h want %h", r, {32'hF000, 3'b000}); else passes++;
    consume();
  endtask

  task automatic test_misc();
    int lat; logic [34:0] r;
    run_op(4'b1111, 32'h123, 32'h456, lat, r);
    checks++; if (r !== 35'h0) $display("FAIL bad_ctrl: got %h want %h", r, 35'h0); else passes++;
    consume();
    run_op(4'b1000, 32'd7, 32'd9, lat, r);
    checks++; if (r !== {32'd63, 3'b000}) $display("FAIL mul_capture: got %h want %h", r, {32'd63, 3'b000}); else passes++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_mul();
    test_back_to_back();
    test_hold();
    test_reset_busy();
    test_misc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
